// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: time-multiplexes one hex decoder across DIGITS digits.
// It provides tear-free frame-aligned updates, a per-slot dead-time to prevent ghosting,
// and optional leading-zero blanking.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned DEAD     = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [3:0]            nib,
  output logic [DIGITS-1:0]     digit_an,
  output logic                  dp_out,
  output logic                  frame_done
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CntMax  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] DeadCnt = CW'(DEAD);
  localparam logic [IW-1:0] IdxMax  = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;

  logic                cnt_last;
  logic                boundary;
  logic [DIGITS-1:0]   blank;

  assign cnt_last = (cnt_q == CntMax);
  // Last cycle of the last digit slot; the displayed value may only change here.
  assign boundary = en && cnt_last && (idx_q == IdxMax);

  // Next-state: prescaler, digit index, and the pending/displayed value handshake.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    disp_dp_d    = disp_dp_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
      // No frame is running, so updates can land immediately.
      if (load) begin
        disp_d       = value;
        disp_dp_d    = dp_in;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        disp_d       = pend_q;
        disp_dp_d    = pend_dp_q;
        pend_valid_d = 1'b0;
      end
    end else begin
      if (cnt_last) begin
        cnt_d = '0;
        idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (load && boundary) begin
        disp_d       = value;
        disp_dp_d    = dp_in;
        pend_valid_d = 1'b0;
      end else if (load) begin
        pend_d       = value;
        pend_dp_d    = dp_in;
        pend_valid_d = 1'b1;
      end else if (boundary && pend_valid_q) begin
        disp_d       = pend_q;
        disp_dp_d    = pend_dp_q;
        pend_valid_d = 1'b0;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Leading-zero blanking: digit i>0 goes dark when it and every higher nibble are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (disp_q[4*i +: 4] == 4'h0);
      blank[i] = lz_blank && zero_run;
    end
  end

  // Digit enable: only the current digit, past the dead-time, and not blanked.
  always_comb begin
    digit_an = '1;
    if (en && (cnt_q >= DeadCnt) && !blank[idx_q]) begin
      digit_an[idx_q] = 1'b0;
    end
  end

  assign nib        = disp_q[{idx_q, 2'b00} +: 4];
  assign dp_out     = disp_dp_q[idx_q] && !digit_an[idx_q];
  assign frame_done = boundary;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl (DIGITS=4, PRESCALE=4, DEAD=1). A driver pushes per-cycle
// expected outputs from a slot-arithmetic reference model; a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int D = 4;
  localparam int P = 4;
  localparam int DT = 1;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  nib;
  logic [3:0]  digit_an;
  logic        dp_out;
  logic        frame_done;

  seg_scan_ctrl #(
    .DIGITS   (D),
    .PRESCALE (P),
    .DEAD     (DT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .nib        (nib),
    .digit_an   (digit_an),
    .dp_out     (dp_out),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cur_lz   = 1'b0;

  // Reference model: m_t counts cycles since the scan (re)started.
  int          m_t;
  logic [15:0] m_disp;
  logic [3:0]  m_dp;
  logic [15:0] m_pend;
  logic [3:0]  m_pend_dp;
  bit          m_pv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required a normal finish");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_t = 0; m_disp = '0; m_dp = '0; m_pend = '0; m_pend_dp = '0; m_pv = 1'b0;
  endfunction

  function automatic exp_t model_out(input bit e, input bit lz);
    exp_t r;
    int   idx;
    int   phase;
    bit   lit;
    idx   = (m_t / P) % D;
    phase = m_t % P;
    lit   = e && (phase >= DT) && !(lz && idx > 0 && (m_disp >> (4 * idx)) == 16'h0);
    r.an  = lit ? ~(4'b0001 << idx) : 4'b1111;
    r.nib = 4'((m_disp >> (4 * idx)) & 16'hF);
    r.dp  = lit && m_dp[idx];
    r.fd  = e && (phase == P - 1) && (idx == D - 1);
    return r;
  endfunction

  function automatic void model_step(input bit e, input bit ld, input logic [15:0] v,
                                     input logic [3:0] d);
    bit bnd;
    bnd = e && (m_t % P == P - 1) && ((m_t / P) % D == D - 1);
    if (!e) begin
      m_t = 0;
      if (ld) begin
        m_disp = v; m_dp = d; m_pv = 1'b0;
      end else if (m_pv) begin
        m_disp = m_pend; m_dp = m_pend_dp; m_pv = 1'b0;
      end
    end else begin
      m_t = m_t + 1;
      if (ld && bnd) begin
        m_disp = v; m_dp = d; m_pv = 1'b0;
      end else if (ld) begin
        m_pend = v; m_pend_dp = d; m_pv = 1'b1;
      end else if (bnd && m_pv) begin
        m_disp = m_pend; m_dp = m_pend_dp; m_pv = 1'b0;
      end
    end
  endfunction

  // Monitor: one scoreboard entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (digit_an !== e.an || nib !== e.nib || dp_out !== e.dp || frame_done !== e.fd) begin
        n_fail++;
        $display("FAIL scan @%0t: got an=%b nib=%h dp=%b fd=%b, expected an=%b nib=%h dp=%b fd=%b",
                 $time, digit_an, nib, dp_out, frame_done, e.an, e.nib, e.dp, e.fd);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit e, input bit ld, input logic [15:0] v, input logic [3:0] d);
    en = e; load = ld; value = v; dp_in = d; lz_blank = cur_lz;
    exp_q.push_back(model_out(e, cur_lz));
    @(posedge clk);
    model_step(e, ld, v, d);
    #1;
  endtask

  task automatic run_until(input int phase16);
    while ((m_t % 16) != phase16) cycle(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_an", 16'(digit_an), 16'hF);
    check("rst_nib", 16'(nib), 16'h0);
    check("rst_fd", 16'(frame_done), 16'h0);
    check("rst_dp", 16'(dp_out), 16'h0);
    en = 1'b0; load = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = '0; dp_in = '0; lz_blank = 1'b0;
    model_reset();
    do_reset();

    // Scan order over two frames.
    cycle(1'b0, 1'b1, 16'h1234, 4'b0100);
    repeat (8) cycle(1'b1, 1'b0, 16'h0, 4'h0);
    check("slot2_dead_an", 16'(digit_an), 16'hF);
    cycle(1'b1, 1'b0, 16'h0, 4'h0);
    check("slot2_an", 16'(digit_an), 16'hB);
    check("slot2_dp", 16'(dp_out), 16'h1);
    repeat (23) cycle(1'b1, 1'b0, 16'h0, 4'h0);

    // Asynchronous reset mid-scan, then restart from digit 0 with disp cleared.
    run_until(6);
    do_reset();
    repeat (20) cycle(1'b1, 1'b0, 16'h0, 4'h0);

    // Tear-free update: load during slot 1, old frame completes.
    cycle(1'b0, 1'b1, 16'h1234, 4'b0000);
    run_until(5);
    cycle(1'b1, 1'b1, 16'hABCD, 4'b0000);
    run_until(9);
    check("tear_nib2", 16'(nib), 16'h2);
    run_until(13);
    check("tear_nib3", 16'(nib), 16'h1);
    run_until(1);
    check("tear_next_nib", 16'(nib), 16'hD);
    run_until(13);

    // Boundary bypass.
    run_until(15);
    cycle(1'b1, 1'b1, 16'h5678, 4'b0000);
    cycle(1'b1, 1'b0, 16'h0, 4'h0);
    check("bypass_an", 16'(digit_an), 16'hE);
    check("bypass_nib", 16'(nib), 16'h8);
    run_until(0);

    // Leading-zero blanking.
    cur_lz = 1'b1;
    cycle(1'b0, 1'b1, 16'h0050, 4'b1111);
    run_until(5);
    check("lz_digit1", 16'(digit_an), 16'hD);
    check("lz_nib1", 16'(nib), 16'h5);
    run_until(9);
    check("lz_digit2", 16'(digit_an), 16'hF);
    run_until(0);
    cycle(1'b0, 1'b1, 16'h0000, 4'b1111);
    run_until(1);
    check("lz0_digit0", 16'(digit_an), 16'hE);
    check("lz0_dp0", 16'(dp_out), 16'h1);
    run_until(5);
    check("lz0_digit1", 16'(digit_an), 16'hF);
    check("lz0_dp1", 16'(dp_out), 16'h0);
    run_until(0);
    cur_lz = 1'b0;

    // Enable off: immediate load, then one dead cycle after re-enable.
    run_until(6);
    cycle(1'b0, 1'b0, 16'h0, 4'h0);
    check("dis_an", 16'(digit_an), 16'hF);
    cycle(1'b0, 1'b1, 16'h0009, 4'h0);
    check("dis_nib", 16'(nib), 16'h9);
    cycle(1'b1, 1'b0, 16'h0, 4'h0);
    check("reen_an", 16'(digit_an), 16'hE);
    check("reen_nib", 16'(nib), 16'h9);
    repeat (10) cycle(1'b1, 1'b0, 16'h0, 4'h0);

    // Randomized traffic with a mid-run reset.
    for (int i = 0; i < 800; i++) begin
      bit          e;
      bit          ld;
      logic [15:0] v;
      int          k;
      if (i == 400) do_reset();
      if ($urandom_range(0, 31) == 0) cur_lz = ~cur_lz;
      e  = ($urandom_range(0, 19) != 0);
      ld = ($urandom_range(0, 7) == 0);
      k  = $urandom_range(0, 4);
      v  = 16'($urandom) & (16'hFFFF >> (4 * k));
      cycle(e, ld, v, 4'($urandom_range(0, 15)));
    end
    load = 1'b0;
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
